// File: rtl/spi_cntrl_if.sv
// User-side start/done handshake for the SPI byte controller.
interface spi_cntrl_if;
  logic       start;
  logic [7:0] data_to_send;
  logic       hold_cs;
  logic [7:0] data_received;
  logic       busy;
  logic       done;

  modport master (
    output start, data_to_send, hold_cs,
    input  data_received, busy, done
  );

  modport slave (
    input  start, data_to_send, hold_cs,
    output data_received, busy, done
  );
endinterface

// File: rtl/spi_cntrl.sv
// SPI mode-0 master: one byte per transaction, MSB first, optional CS hold
// across consecutive bytes.
module spi_cntrl #(
  parameter int unsigned CLK_FREQUENCY  = 100_000_000,
  parameter int unsigned SCLK_FREQUENCY = 500_000
) (
  input  logic      clk,
  input  logic      reset,
  spi_cntrl_if.slave usr,
  input  logic      SPI_MISO,
  output logic      SPI_SCLK,
  output logic      SPI_MOSI,
  output logic      SPI_CS
);

  localparam int unsigned HALF_PERIOD = CLK_FREQUENCY / (2 * SCLK_FREQUENCY);
  localparam int unsigned CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $error("spi_cntrl: HALF_PERIOD must be at least 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_END,
    S_WAIT_NEXT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] half_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_shift;
  logic [7:0]       rx_shift;
  logic             hold_q;
  logic             half_term;

  assign half_term = (half_cnt == CNT_W'(HALF_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      half_cnt          <= '0;
      bit_cnt           <= '0;
      tx_shift          <= '0;
      rx_shift          <= '0;
      hold_q            <= 1'b0;
      SPI_SCLK          <= 1'b0;
      SPI_MOSI          <= 1'b0;
      SPI_CS            <= 1'b1;
      usr.data_received <= '0;
      usr.busy          <= 1'b0;
      usr.done          <= 1'b0;
    end else begin
      usr.done <= 1'b0;
      case (state)
        S_IDLE, S_WAIT_NEXT: begin
          SPI_SCLK <= 1'b0;
          if (usr.start) begin
            tx_shift <= usr.data_to_send;
            hold_q   <= usr.hold_cs;
            SPI_MOSI <= usr.data_to_send[7];
            SPI_CS   <= 1'b0;
            usr.busy <= 1'b1;
            bit_cnt  <= '0;
            half_cnt <= '0;
            state    <= S_SETUP;
          end
        end
        // SETUP and LOW both end with a rising edge that samples MISO
        S_SETUP, S_LOW: begin
          if (half_term) begin
            half_cnt <= '0;
            SPI_SCLK <= 1'b1;
            rx_shift <= {rx_shift[6:0], SPI_MISO};
            state    <= S_HIGH;
          end else begin
            half_cnt <= half_cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (half_term) begin
            half_cnt <= '0;
            SPI_SCLK <= 1'b0;
            if (bit_cnt == 3'd7) begin
              state <= S_END;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              tx_shift <= {tx_shift[6:0], 1'b0};
              SPI_MOSI <= tx_shift[6];
              state    <= S_LOW;
            end
          end else begin
            half_cnt <= half_cnt + CNT_W'(1);
          end
        end
        // CS hold time after the last falling edge, then publish the byte
        S_END: begin
          if (half_term) begin
            half_cnt          <= '0;
            usr.data_received <= rx_shift;
            usr.done          <= 1'b1;
            usr.busy          <= 1'b0;
            if (hold_q) begin
              state <= S_WAIT_NEXT;
            end else begin
              SPI_CS <= 1'b1;
              state  <= S_IDLE;
            end
          end else begin
            half_cnt <= half_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          SPI_SCLK <= 1'b0;
          SPI_CS   <= 1'b1;
          usr.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cntrl.sv
// Randomized self-checking bench for spi_cntrl with loopback and a behavioural SPI slave.
module tb_spi_cntrl;
  localparam int unsigned CLK_F  = 100_000_000;
  localparam int unsigned SCLK_F = 500_000;
  localparam int unsigned HP     = CLK_F / (2 * SCLK_F);
  localparam int unsigned LAT    = 17 * HP + 1;

  logic clk = 1'b0;
  logic reset;
  logic spi_miso, spi_sclk, spi_mosi, spi_cs;

  spi_cntrl_if u_if ();

  spi_cntrl #(.CLK_FREQUENCY(CLK_F), .SCLK_FREQUENCY(SCLK_F)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .usr      (u_if),
    .SPI_MISO (spi_miso),
    .SPI_SCLK (spi_sclk),
    .SPI_MOSI (spi_mosi),
    .SPI_CS   (spi_cs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // slave model and bus monitor state
  logic       miso_sel = 1'b0;
  logic [7:0] slv_send = 8'h00;
  logic [7:0] slv_tx   = 8'h00;
  logic [7:0] slv_rx   = 8'h00;
  logic       sclk_q = 1'b0, cs_q = 1'b1, mosi_q = 1'b0, done_q = 1'b0, phase_ok = 1'b0;
  int         phase_len = 0, phase_checks = 0, bad_phase = 0, mosi_bad = 0;
  int         rises = 0, cs_rises = 0, done_cnt = 0, done_wide = 0;

  assign spi_miso = miso_sel ? slv_tx[7] : spi_mosi;

  always @(posedge clk) begin
    sclk_q <= spi_sclk;
    cs_q   <= spi_cs;
    mosi_q <= spi_mosi;
    done_q <= u_if.done;
    if (reset || spi_cs || u_if.done) begin
      phase_len <= 1;
      phase_ok  <= 1'b0;
    end else if (spi_sclk != sclk_q) begin
      if (phase_ok) begin
        phase_checks <= phase_checks + 1;
        if (phase_len != int'(HP)) bad_phase <= bad_phase + 1;
      end
      phase_ok  <= 1'b1;
      phase_len <= 1;
      if (spi_sclk && (spi_mosi !== mosi_q)) mosi_bad <= mosi_bad + 1;
    end else begin
      phase_len <= phase_len + 1;
    end
    if (spi_sclk && !sclk_q) rises <= rises + 1;
    if (spi_cs && !cs_q) cs_rises <= cs_rises + 1;
    if (u_if.done) done_cnt <= done_cnt + 1;
    if (u_if.done && done_q) done_wide <= done_wide + 1;
    if (!spi_cs && cs_q) slv_tx <= slv_send;
    else if (!spi_cs && sclk_q && !spi_sclk) slv_tx <= {slv_tx[6:0], 1'b0};
    if (!spi_cs && spi_sclk && !sclk_q) slv_rx <= {slv_rx[6:0], spi_mosi};
  end

  // Stimulus helper: issue one start and wait (bounded) for done.
  task automatic run_xfer(input logic [7:0] d, input logic hc, output int lat, output logic got);
    u_if.start = 1'b1; u_if.data_to_send = d; u_if.hold_cs = hc;
    @(posedge clk); #1;
    u_if.start = 1'b0; u_if.data_to_send = 8'($urandom);
    lat = 1;
    while (!u_if.done && lat < 5000) begin @(posedge clk); #1; lat++; end
    got = u_if.done;
  endtask

  task automatic test_reset();
    reset = 1'b1; u_if.start = 1'b1; u_if.data_to_send = 8'hA5; u_if.hold_cs = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({spi_cs, spi_sclk, spi_mosi, u_if.busy, u_if.done} !== 5'b10000)
      $display("FAIL reset_ctrl: cs/sclk/mosi/busy/done=%b want 10000",
               {spi_cs, spi_sclk, spi_mosi, u_if.busy, u_if.done});
    else n_pass++;
    n_checks++;
    if (u_if.data_received !== 8'h00) $display("FAIL reset_rx: got %h want 00", u_if.data_received);
    else n_pass++;
    u_if.start = 1'b0; reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_loopback();
    int lat; logic got; int r0;
    miso_sel = 1'b0; r0 = rises;
    run_xfer(8'hA5, 1'b0, lat, got);
    n_checks++;
    if (!got || lat != int'(LAT)) $display("FAIL loop_latency: got %0d (done=%b) want %0d", lat, got, LAT);
    else n_pass++;
    n_checks++;
    if (u_if.data_received !== 8'hA5) $display("FAIL loop_data: got %h want a5", u_if.data_received);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (u_if.done !== 1'b0 || spi_cs !== 1'b1 || u_if.busy !== 1'b0)
      $display("FAIL loop_after: done=%b cs=%b busy=%b want 0 1 0", u_if.done, spi_cs, u_if.busy);
    else n_pass++;
    n_checks++;
    if (rises - r0 != 8) $display("FAIL loop_rises: got %0d want 8", rises - r0);
    else n_pass++;
  endtask

  task automatic test_subunit();
    int lat; logic got;
    miso_sel = 1'b1; slv_send = 8'h3C;
    run_xfer(8'hC3, 1'b0, lat, got);
    n_checks++;
    if (!got || u_if.data_received !== 8'h3C)
      $display("FAIL sub_rx: got %h (done=%b) want 3c", u_if.data_received, got);
    else n_pass++;
    n_checks++;
    if (slv_rx !== 8'hC3) $display("FAIL sub_tx: slave got %h want c3", slv_rx);
    else n_pass++;
    miso_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_hold_cs();
    int lat; logic got; int r0, c0;
    miso_sel = 1'b0; r0 = rises; c0 = cs_rises;
    run_xfer(8'h12, 1'b1, lat, got);
    n_checks++;
    if (!got || u_if.data_received !== 8'h12) $display("FAIL hold_b0: got %h want 12", u_if.data_received);
    else n_pass++;
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (spi_cs !== 1'b0 || cs_rises != c0) $display("FAIL hold_gap: cs=%b cs_rises=%0d want 0 0", spi_cs, cs_rises - c0);
    else n_pass++;
    run_xfer(8'h34, 1'b0, lat, got);
    n_checks++;
    if (!got || u_if.data_received !== 8'h34) $display("FAIL hold_b1: got %h want 34", u_if.data_received);
    else n_pass++;
    n_checks++;
    if (cs_rises != c0) $display("FAIL hold_cs_early: cs rose %0d times before second done", cs_rises - c0);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (spi_cs !== 1'b1 || cs_rises - c0 != 1 || rises - r0 != 16)
      $display("FAIL hold_end: cs=%b cs_rises=%0d sclk_rises=%0d want 1 1 16", spi_cs, cs_rises - c0, rises - r0);
    else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [7:0] orig; int lat; int d0;
    orig = 8'($urandom_range(0, 254));
    miso_sel = 1'b0; d0 = done_cnt;
    u_if.start = 1'b1; u_if.data_to_send = orig; u_if.hold_cs = 1'b0;
    @(posedge clk); #1;
    u_if.start = 1'b0; lat = 1;
    repeat (499) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (u_if.busy !== 1'b1) $display("FAIL ign_busy: got %b want 1", u_if.busy);
    else n_pass++;
    u_if.start = 1'b1; u_if.data_to_send = 8'hFF; u_if.hold_cs = 1'b1;
    @(posedge clk); #1; lat++;
    u_if.start = 1'b0; u_if.data_to_send = 8'($urandom);
    while (!u_if.done && lat < 5000) begin @(posedge clk); #1; lat++; end
    n_checks++;
    if (lat != int'(LAT) || u_if.data_received !== orig)
      $display("FAIL ign_data: got %h lat %0d want %h lat %0d", u_if.data_received, lat, orig, LAT);
    else n_pass++;
    repeat (4 * HP) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt - d0 != 1 || spi_cs !== 1'b1)
      $display("FAIL ign_single: dones=%0d cs=%b want 1 1", done_cnt - d0, spi_cs);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat; logic got; int d0;
    miso_sel = 1'b0; d0 = done_cnt;
    u_if.start = 1'b1; u_if.data_to_send = 8'h96; u_if.hold_cs = 1'b0;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (9 * HP + 10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if ({spi_cs, spi_sclk, u_if.busy, u_if.done} !== 4'b1000 || u_if.data_received !== 8'h00)
      $display("FAIL rst_mid: cs/sclk/busy/done=%b rx=%h want 1000 00",
               {spi_cs, spi_sclk, u_if.busy, u_if.done}, u_if.data_received);
    else n_pass++;
    repeat (12 * HP) @(posedge clk);
    #1;
    n_checks++;
    if (done_cnt != d0) $display("FAIL rst_no_done: got %0d dones want 0", done_cnt - d0);
    else n_pass++;
    run_xfer(8'h5A, 1'b0, lat, got);
    n_checks++;
    if (!got || lat != int'(LAT) || u_if.data_received !== 8'h5A)
      $display("FAIL rst_recover: got %h lat %0d want 5a lat %0d", u_if.data_received, lat, LAT);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic got; logic [7:0] tx, exp_rx; logic hc, sel;
    for (int i = 0; i < 4; i++) begin
      tx = 8'($urandom); hc = 1'($urandom); slv_send = 8'($urandom);
      sel = spi_cs ? 1'($urandom) : 1'b0;
      miso_sel = sel;
      exp_rx = sel ? slv_send : tx;
      run_xfer(tx, hc, lat, got);
      n_checks++;
      if (!got || lat != int'(LAT) || u_if.data_received !== exp_rx)
        $display("FAIL rand_%0d: rx %h lat %0d want %h lat %0d", i, u_if.data_received, lat, exp_rx, LAT);
      else n_pass++;
      n_checks++;
      if (spi_cs !== !hc || (sel && slv_rx !== tx))
        $display("FAIL rand_side_%0d: cs=%b slave=%h want cs=%b slave=%h", i, spi_cs, slv_rx, !hc, tx);
      else n_pass++;
      repeat (1 + $urandom_range(0, 30)) @(posedge clk);
      #1;
    end
    miso_sel = 1'b0;
    if (!spi_cs) begin
      run_xfer(8'h00, 1'b0, lat, got);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sclk_timing();
    n_checks++;
    if (phase_checks == 0 || bad_phase != 0)
      $display("FAIL sclk_phase: %0d bad of %0d phases, want 0 bad", bad_phase, phase_checks);
    else n_pass++;
    n_checks++;
    if (mosi_bad != 0) $display("FAIL mosi_stable: %0d changes at SCLK rise, want 0", mosi_bad);
    else n_pass++;
    n_checks++;
    if (done_wide != 0) $display("FAIL done_pulse: %0d multi-cycle done pulses, want 0", done_wide);
    else n_pass++;
  endtask

  initial begin
    reset = 1'b1;
    u_if.start = 1'b0; u_if.data_to_send = 8'h00; u_if.hold_cs = 1'b0;
    test_reset();
    test_loopback();
    test_subunit();
    test_hold_cs();
    test_start_ignored();
    test_reset_mid();
    test_random();
    test_sclk_timing();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
